// File: rtl/mux_out_sync_pkg.sv
// Shared FSM encoding and constants for the minigame output multiplexer.
package mux_out_sync_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    ATIVO = 2'd1,
    TROCA = 2'd2
  } state_t;

  // Truncated to SEL_W at the point of use; any width stays all-ones.
  localparam logic [31:0] SEL_MENU = '1;

endpackage

// File: rtl/mux_out_sync_sel_slice.sv
// Combinational extractor of channel idx from a packed N*W bus.
// An index outside 0..N-1 yields zero.
module mux_out_sync_sel_slice #(
  parameter int N     = 3,
  parameter int W     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N*W-1:0]   bus,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     dat
);

  always_comb begin
    dat = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) dat = bus[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_out_sync.sv
// Registered minigame/menu output multiplexer with blanking on selection change.
// Latency: one cycle from selected channel inputs to board outputs.
module mux_out_sync
  import mux_out_sync_pkg::*;
#(
  parameter int N_JOGOS      = 3,
  parameter int SEL_W        = 2,
  parameter int LEDS_W       = 3,
  parameter int ESTADO_W     = 4,
  parameter int JOGADA_W     = 7,
  parameter int PONT_W       = 3,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SEL_W-1:0]             minigame,
  input  logic [N_JOGOS*LEDS_W-1:0]    leds_in,
  input  logic [N_JOGOS*ESTADO_W-1:0]  estado_in,
  input  logic [N_JOGOS*JOGADA_W-1:0]  jogada_in,
  input  logic [N_JOGOS*PONT_W-1:0]    pontuacao_in,
  input  logic [N_JOGOS-1:0]           pronto_in,
  input  logic [ESTADO_W-1:0]          estado_inicial,
  output logic [LEDS_W-1:0]            leds_out,
  output logic [ESTADO_W-1:0]          estado_out,
  output logic [JOGADA_W-1:0]          jogada_out,
  output logic [PONT_W-1:0]            pontuacao_out,
  output logic                         pronto_out,
  output logic [SEL_W-1:0]             sel_ativo,
  output logic                         troca,
  output logic [PONT_W-1:0]            pontuacao_final
);

  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] MENU_SEL = SEL_W'(SEL_MENU);
  localparam logic [SEL_W-1:0] N_SEL    = SEL_W'(N_JOGOS);

  state_t           state, nxt_state, target_state;
  logic [SEL_W-1:0] sel_req, nxt_sel, target_sel;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             nxt_troca, change, in_range;
  logic             pronto_prev, same_ch;

  logic [LEDS_W-1:0]   leds_sl;
  logic [ESTADO_W-1:0] estado_sl;
  logic [JOGADA_W-1:0] jogada_sl;
  logic [PONT_W-1:0]   pont_sl;
  logic                pronto_sl;

  // Slices follow the channel that will own the outputs after this edge.
  mux_out_sync_sel_slice #(.N(N_JOGOS), .W(LEDS_W),   .IDX_W(SEL_W)) u_leds
    (.bus(leds_in),      .idx(nxt_sel), .dat(leds_sl));
  mux_out_sync_sel_slice #(.N(N_JOGOS), .W(ESTADO_W), .IDX_W(SEL_W)) u_estado
    (.bus(estado_in),    .idx(nxt_sel), .dat(estado_sl));
  mux_out_sync_sel_slice #(.N(N_JOGOS), .W(JOGADA_W), .IDX_W(SEL_W)) u_jogada
    (.bus(jogada_in),    .idx(nxt_sel), .dat(jogada_sl));
  mux_out_sync_sel_slice #(.N(N_JOGOS), .W(PONT_W),   .IDX_W(SEL_W)) u_pont
    (.bus(pontuacao_in), .idx(nxt_sel), .dat(pont_sl));
  mux_out_sync_sel_slice #(.N(N_JOGOS), .W(1),        .IDX_W(SEL_W)) u_pronto
    (.bus(pronto_in),    .idx(nxt_sel), .dat(pronto_sl));

  assign change       = (minigame != sel_req);
  assign in_range     = (minigame < N_SEL);
  assign target_state = in_range ? ATIVO : MENU;
  assign target_sel   = in_range ? minigame : MENU_SEL;
  assign same_ch      = (state == ATIVO) && (nxt_sel == sel_ativo);

  always_comb begin
    nxt_state = state;
    nxt_sel   = sel_ativo;
    nxt_cnt   = cnt;
    nxt_troca = troca;
    case (state)
      MENU, ATIVO: begin
        if (change) begin
          if (BLANK_CYCLES > 0) begin
            nxt_state = TROCA;
            nxt_cnt   = CNT_LOAD;
            nxt_troca = 1'b1;
          end else begin
            nxt_state = target_state;
            nxt_sel   = target_sel;
          end
        end
      end
      TROCA: begin
        if (change) begin
          nxt_cnt = CNT_LOAD;
        end else if (cnt == '0) begin
          nxt_state = target_state;
          nxt_sel   = target_sel;
          nxt_troca = 1'b0;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      default: begin
        nxt_state = MENU;
        nxt_sel   = MENU_SEL;
        nxt_troca = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= MENU;
      sel_req         <= MENU_SEL;
      cnt             <= '0;
      sel_ativo       <= MENU_SEL;
      troca           <= 1'b0;
      pronto_prev     <= 1'b0;
      leds_out        <= '0;
      estado_out      <= estado_inicial;
      jogada_out      <= '0;
      pontuacao_out   <= '0;
      pronto_out      <= 1'b0;
      pontuacao_final <= '0;
    end else begin
      state     <= nxt_state;
      sel_req   <= minigame;
      cnt       <= nxt_cnt;
      sel_ativo <= nxt_sel;
      troca     <= nxt_troca;

      if (nxt_state == ATIVO) begin
        leds_out      <= leds_sl;
        estado_out    <= estado_sl;
        jogada_out    <= jogada_sl;
        pontuacao_out <= pont_sl;
        pronto_out    <= pronto_sl;
      end else begin
        leds_out      <= '0;
        estado_out    <= estado_inicial;
        jogada_out    <= '0;
        pontuacao_out <= '0;
        pronto_out    <= 1'b0;
      end

      // Edge history restarts whenever a channel (re)gains the outputs.
      pronto_prev <= (same_ch && nxt_state == ATIVO) ? pronto_sl : 1'b0;
      if (same_ch && pronto_sl && !pronto_prev) pontuacao_final <= pont_sl;
    end
  end

endmodule

// File: tb/tb_mux_out_sync.sv
module tb_mux_out_sync;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  minigame;
  logic [8:0]  leds_in;
  logic [11:0] estado_in;
  logic [20:0] jogada_in;
  logic [8:0]  pontuacao_in;
  logic [2:0]  pronto_in;
  logic [3:0]  estado_inicial;

  logic [2:0] a_leds, z_leds;
  logic [3:0] a_estado, z_estado;
  logic [6:0] a_jogada, z_jogada;
  logic [2:0] a_pont, z_pont, a_final, z_final;
  logic       a_pronto, z_pronto, a_troca, z_troca;
  logic [1:0] a_sel, z_sel;
  logic       z_troca_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mux_out_sync dut (
    .clock(clock), .reset(reset), .minigame(minigame),
    .leds_in(leds_in), .estado_in(estado_in), .jogada_in(jogada_in),
    .pontuacao_in(pontuacao_in), .pronto_in(pronto_in), .estado_inicial(estado_inicial),
    .leds_out(a_leds), .estado_out(a_estado), .jogada_out(a_jogada),
    .pontuacao_out(a_pont), .pronto_out(a_pronto), .sel_ativo(a_sel),
    .troca(a_troca), .pontuacao_final(a_final)
  );

  mux_out_sync #(.BLANK_CYCLES(0)) dut_z (
    .clock(clock), .reset(reset), .minigame(minigame),
    .leds_in(leds_in), .estado_in(estado_in), .jogada_in(jogada_in),
    .pontuacao_in(pontuacao_in), .pronto_in(pronto_in), .estado_inicial(estado_inicial),
    .leds_out(z_leds), .estado_out(z_estado), .jogada_out(z_jogada),
    .pontuacao_out(z_pont), .pronto_out(z_pronto), .sel_ativo(z_sel),
    .troca(z_troca), .pontuacao_final(z_final)
  );

  always @(posedge clock) if (z_troca === 1'b1) z_troca_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_menu(input string tag);
    chk({tag, "_troca"}, a_troca, 0);
    chk({tag, "_sel"}, a_sel, 3);
    chk({tag, "_estado"}, a_estado, 4'hA);
    chk({tag, "_leds"}, a_leds, 0);
    chk({tag, "_jogada"}, a_jogada, 0);
    chk({tag, "_pont"}, a_pont, 0);
    chk({tag, "_pronto"}, a_pronto, 0);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_troca"}, a_troca, 1);
    chk({tag, "_leds"}, a_leds, 0);
    chk({tag, "_jogada"}, a_jogada, 0);
    chk({tag, "_estado"}, a_estado, 4'hA);
  endtask

  initial begin
    reset          = 1'b0;
    minigame       = 2'd3;
    estado_inicial = 4'hA;
    leds_in        = {3'b011, 3'b101, 3'b110};
    estado_in      = {4'h3, 4'h2, 4'h1};
    jogada_in      = {7'h22, 7'h11, 7'h05};
    pontuacao_in   = {3'd6, 3'd2, 3'd1};
    pronto_in      = 3'b000;

    // 1: reset
    step(); step();
    chk_menu("rst");
    chk("rst_final", a_final, 0);
    chk("rst_z_sel", z_sel, 3);
    reset = 1'b1;
    step();
    chk_menu("menu_idle");

    // 2: 3 -> 1 with a 4-cycle blanking window
    minigame = 2'd1;
    step();
    chk_blank("t2_b0");
    chk("t2_sel_hold", a_sel, 3);
    chk("t2_z_leds", z_leds, 3'b101);
    chk("t2_z_sel", z_sel, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_blank($sformatf("t2_b%0d", i));
    end
    step();
    chk("t2_troca_end", a_troca, 0);
    chk("t2_sel", a_sel, 1);
    chk("t2_leds", a_leds, 3'b101);
    chk("t2_estado", a_estado, 4'h2);
    chk("t2_jogada", a_jogada, 7'h11);
    chk("t2_pont", a_pont, 3'd2);
    leds_in[5:3] = 3'b010;
    step();
    chk("t2_track", a_leds, 3'b010);

    // 3: 1 -> 0, then 2 during the third blanking cycle
    minigame = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_blank($sformatf("t3_first%0d", i));
    end
    minigame = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_blank($sformatf("t3_restart%0d", i));
    end
    step();
    chk("t3_troca_end", a_troca, 0);
    chk("t3_sel", a_sel, 2);
    chk("t3_leds", a_leds, 3'b011);
    chk("t3_estado", a_estado, 4'h3);
    chk("t3_z_sel", z_sel, 2);

    // 4: final score capture on the active channel only
    pronto_in = 3'b001;
    step();
    chk("t4_inactive_pronto", a_final, 0);
    chk("t4_pronto_out_low", a_pronto, 0);
    pronto_in = 3'b101;
    step();
    chk("t4_final", a_final, 3'd6);
    chk("t4_pronto_out", a_pronto, 1);
    chk("t4_z_final", z_final, 3'd6);
    pontuacao_in[8:6] = 3'd3;
    step();
    chk("t4_no_relatch", a_final, 3'd6);
    chk("t4_pont_track", a_pont, 3'd3);
    minigame = 2'd3;
    for (int i = 0; i < 5; i++) step();
    chk_menu("t4_menu");
    chk("t4_final_hold", a_final, 3'd6);
    chk("t4_z_menu_sel", z_sel, 3);
    chk("t4_z_final_hold", z_final, 3'd6);
    pronto_in = 3'b000;
    pontuacao_in[8:6] = 3'd6;

    // 5: zero-blanking instance switches immediately
    minigame = 2'd0;
    step();
    chk("t5_z_sel0", z_sel, 0);
    chk("t5_z_leds0", z_leds, 3'b110);
    minigame = 2'd2;
    step();
    chk("t5_z_sel2", z_sel, 2);
    chk("t5_z_leds2", z_leds, 3'b011);
    chk("t5_z_estado2", z_estado, 4'h3);
    chk("t5_z_jogada2", z_jogada, 7'h22);

    // 6: reset in the middle of blanking, then a clean window
    chk("t6_in_troca", a_troca, 1);
    reset = 1'b0;
    step();
    chk_menu("t6_rst");
    chk("t6_final_clr", a_final, 0);
    reset = 1'b1;
    minigame = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_blank($sformatf("t6_b%0d", i));
    end
    step();
    chk("t6_troca_end", a_troca, 0);
    chk("t6_sel", a_sel, 0);
    chk("t6_leds", a_leds, 3'b110);
    chk("t6_jogada", a_jogada, 7'h05);

    chk("z_troca_never", z_troca_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
